// File: rtl/uart_rx_if.sv
// Receiver-side output bundle for uart_rx: received word, completion strobe,
// framing error and busy indication.
interface uart_rx_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data_o;
   logic                 rx_done_o;
   logic                 frame_err_o;
   logic                 busy_o;

   modport master (
      output data_o,
      output rx_done_o,
      output frame_err_o,
      output busy_o
   );

   modport slave (
      input data_o,
      input rx_done_o,
      input frame_err_o,
      input busy_o
   );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: 1 start bit, DATA_BITS data bits LSB first,
// 1 stop bit sampled at its midpoint so a back-to-back start bit is not missed.
module uart_rx #(
   parameter int DATA_BITS = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [10:0] div_i,
   input  logic        rx_i,
   uart_rx_if.master   bus
);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam logic [2:0] N_LAST = 3'(DATA_BITS - 1);

   logic                 rx_meta_reg;
   logic                 rx_s;
   logic [10:0]          tick_cnt_reg;
   logic                 tick;
   state_t               state_reg;
   logic [3:0]           s_cnt_reg;
   logic [2:0]           n_reg;
   logic [DATA_BITS-1:0] shift_reg;
   logic [DATA_BITS-1:0] data_reg;
   logic                 done_reg;
   logic                 ferr_reg;
   logic                 busy_reg;

   // Synchronizer flops reset to the idle line level so reset never looks like a start bit.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_meta_reg <= 1'b1;
         rx_s        <= 1'b1;
      end else begin
         rx_meta_reg <= rx_i;
         rx_s        <= rx_meta_reg;
      end
   end

   // The >= compare lets a lowered divisor take effect without a long wrap.
   assign tick = (tick_cnt_reg >= div_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tick_cnt_reg <= '0;
      end else if (tick) begin
         tick_cnt_reg <= '0;
      end else begin
         tick_cnt_reg <= tick_cnt_reg + 11'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= IDLE;
         s_cnt_reg <= '0;
         n_reg     <= '0;
         shift_reg <= '0;
         data_reg  <= '0;
         done_reg  <= 1'b0;
         ferr_reg  <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (!rx_s) begin
                  state_reg <= START;
                  s_cnt_reg <= '0;
                  busy_reg  <= 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  if (s_cnt_reg == 4'd7) begin
                     if (!rx_s) begin
                        state_reg <= DATA;
                        s_cnt_reg <= '0;
                        n_reg     <= '0;
                     end else begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                     end
                  end else begin
                     s_cnt_reg <= s_cnt_reg + 4'd1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (s_cnt_reg == 4'd15) begin
                     shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                     s_cnt_reg <= '0;
                     if (n_reg == N_LAST) begin
                        state_reg <= STOP;
                     end else begin
                        n_reg <= n_reg + 3'd1;
                     end
                  end else begin
                     s_cnt_reg <= s_cnt_reg + 4'd1;
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  if (s_cnt_reg == 4'd15) begin
                     state_reg <= IDLE;
                     busy_reg  <= 1'b0;
                     data_reg  <= shift_reg;
                     ferr_reg  <= ~rx_s;
                     done_reg  <= 1'b1;
                  end else begin
                     s_cnt_reg <= s_cnt_reg + 4'd1;
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data_o      = data_reg;
   assign bus.rx_done_o   = done_reg;
   assign bus.frame_err_o = ferr_reg;
   assign bus.busy_o      = busy_reg;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a serial-line transmitter model feeds frames, a scoreboard
// queue holds the expected words and a negedge monitor checks every completion.
module tb_uart_rx;
   localparam int DB = 8;

   logic        clk_i  = 1'b0;
   logic        rst_ni = 1'b0;
   logic [10:0] div_i  = 11'd16;
   logic        rx_i   = 1'b1;

   uart_rx_if #(.DATA_BITS(DB)) rif ();

   uart_rx #(.DATA_BITS(DB)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .div_i  (div_i),
      .rx_i   (rx_i),
      .bus    (rif.master)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] d;
      logic       fe;
      int         start;
      int         div;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] last_d  = 8'h00;
   logic       last_fe = 1'b0;
   logic       prev_done = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end else begin
         $display("ok   %s value=%0h", name, act);
      end
   endtask

   // Monitor: every completion pulse pops one expected frame.
   always @(negedge clk_i) begin : monitor
      exp_t e;
      int   lat;
      int   bound;
      if (rif.rx_done_o === 1'b1) begin
         check("done_pulse_width", {31'd0, prev_done}, 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse actual=pulse data %0h required=no pulse", rif.data_o);
         end else begin
            e     = exp_q.pop_front();
            lat   = cyc - e.start;
            bound = 8 * (e.div + 1) * 19 + 4;
            check("frame_data", {24'd0, rif.data_o}, {24'd0, e.d});
            check("frame_err", {31'd0, rif.frame_err_o}, {31'd0, e.fe});
            check("frame_latency_in_bound", {31'd0, (lat <= bound)}, 32'd1);
            last_d  = e.d;
            last_fe = e.fe;
         end
      end
      prev_done = rif.rx_done_o;
   end

   task automatic drive(input logic b, input int clocks);
      rx_i = b;
      repeat (clocks) @(negedge clk_i);
   endtask

   // Line-level transmitter: start, 8 data bits LSB first, stop.
   task automatic send_frame(input logic [7:0] d, input logic stop_ok);
      int   bp;
      exp_t e;
      bp      = 16 * (int'(div_i) + 1);
      e.d     = d;
      e.fe    = !stop_ok;
      e.start = cyc;
      e.div   = int'(div_i);
      exp_q.push_back(e);
      drive(1'b0, bp);
      for (int i = 0; i < 8; i++) drive(d[i], bp);
      if (stop_ok) begin
         drive(1'b1, bp);
      end else begin
         // Low across the stop midpoint, then released before the re-entered
         // start state reaches its own midpoint.
         drive(1'b0, bp * 3 / 4);
         drive(1'b1, bp - bp * 3 / 4);
      end
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 5000) begin
         @(negedge clk_i);
         k++;
      end
      check({name, "_all_frames_seen"}, exp_q.size(), 32'd0);
      exp_q.delete();
      repeat (3) @(negedge clk_i);
      check({name, "_data_hold"}, {24'd0, rif.data_o}, {24'd0, last_d});
      check({name, "_err_hold"}, {31'd0, rif.frame_err_o}, {31'd0, last_fe});
      check({name, "_busy_low"}, {31'd0, rif.busy_o}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_data"}, {24'd0, rif.data_o}, 32'd0);
      check({name, "_done"}, {31'd0, rif.rx_done_o}, 32'd0);
      check({name, "_err"}, {31'd0, rif.frame_err_o}, 32'd0);
      check({name, "_busy"}, {31'd0, rif.busy_o}, 32'd0);
   endtask

   initial begin
      int k;
      int bp;
      repeat (4) @(negedge clk_i);
      check_reset_outputs("in_reset");
      rst_ni = 1'b1;
      drive(1'b1, 20);
      check_reset_outputs("after_reset");

      send_frame(8'hA5, 1'b1);
      drive(1'b1, 40);
      drain("single_a5");

      // Short low pulse: must be rejected at the start-bit midpoint.
      drive(1'b0, 50);
      check("glitch_busy_high", {31'd0, rif.busy_o}, 32'd1);
      drive(1'b0, 50);
      rx_i = 1'b1;
      k = 0;
      while (rif.busy_o === 1'b1 && k < 140) begin
         @(negedge clk_i);
         k++;
      end
      check("glitch_busy_low", {31'd0, rif.busy_o}, 32'd0);
      drive(1'b1, 300);
      check("glitch_no_pulse_data_hold", {24'd0, rif.data_o}, {24'd0, last_d});

      send_frame(8'h3C, 1'b0);
      drive(1'b1, 300);
      drain("bad_stop_3c");
      send_frame(8'h5A, 1'b1);
      drive(1'b1, 40);
      drain("good_5a");

      for (int i = 0; i < 12; i++) send_frame(8'($urandom_range(0, 255)), 1'b1);
      drive(1'b1, 40);
      drain("b2b_div16");

      div_i = 11'd0;
      drive(1'b1, 40);
      for (int i = 0; i < 32; i++) send_frame(8'($urandom_range(0, 255)), 1'b1);
      drive(1'b1, 40);
      drain("b2b_div0");

      div_i = 11'd16;
      drive(1'b1, 100);
      bp = 16 * 17;
      drive(1'b0, bp);
      drive(1'b1, bp * 3 + bp / 2);
      rst_ni = 1'b0;
      repeat (3) @(negedge clk_i);
      check_reset_outputs("mid_frame_reset");
      rst_ni  = 1'b1;
      last_d  = 8'h00;
      last_fe = 1'b0;
      drive(1'b1, 50);
      check("post_reset_no_pulse_data", {24'd0, rif.data_o}, 32'd0);
      send_frame(8'h81, 1'b1);
      drive(1'b1, 40);
      drain("after_reset_81");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..8.
REQ-002 The module SHALL have port clk_i, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-003 The module SHALL have port rst_ni, input, 1 bit, reset, asynchronous and active-low.
REQ-004 The module SHALL have port div_i, input, 11 bits, baud divisor; one oversample tick every div_i+1 clocks, giving 16*(div_i+1) clocks per bit.
REQ-005 The module SHALL have port rx_i, input, 1 bit, asynchronous serial line, idle high.
REQ-006 The module SHALL have port data_o, output, DATA_BITS bits, last received data word.
REQ-007 The module SHALL have port rx_done_o, output, 1 bit, one-clock pulse when a frame completes.
REQ-008 The module SHALL have port frame_err_o, output, 1 bit, stop-bit error flag for the last completed frame.
REQ-009 The module SHALL have port busy_o, output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-010 rx_i SHALL pass through a 2-flop synchronizer before use; all FSM decisions use the synchronized value (rx_s).
REQ-011 A tick counter SHALL count 0..div_i; tick SHALL assert for one clock when counter >= div_i, after which the counter wraps to 0; the counter is free-running and independent of FSM state.
REQ-012 div_i = 0 SHALL yield a tick every clock (16 clocks per bit).
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP, with an oversample counter s_cnt (4 bits) and a bit counter n.
REQ-014 In IDLE, rx_s = 0 SHALL move the FSM to START with s_cnt = 0.
REQ-015 In START, on tick with s_cnt = 7 (start-bit midpoint): if rx_s = 0, the FSM SHALL move to DATA with s_cnt = 0 and n = 0; if rx_s = 1 (glitch), it SHALL return to IDLE with no output change.
REQ-016 In START, on any other tick, s_cnt SHALL increment.
REQ-017 In DATA, on tick with s_cnt = 15, rx_s SHALL be shifted in LSB-first (shift right, new bit into the MSB) and s_cnt cleared; the FSM goes to STOP if n = DATA_BITS-1, else n increments.
REQ-018 In STOP, on tick with s_cnt = 15 (stop-bit midpoint), the FSM SHALL return to IDLE.
- Same clock edge: data_o <= shift register, frame_err_o <= ~rx_s, rx_done_o <= 1 for exactly one clock.
REQ-019 Returning to IDLE at the stop-bit midpoint SHALL allow a back-to-back start bit, with zero idle time, to be detected.
REQ-020 data_o and frame_err_o SHALL hold between rx_done_o pulses.
- A frame with a bad stop bit still updates data_o and pulses rx_done_o.
REQ-021 Latency: rx_done_o SHALL be asserted within 16*(div_i+1)*(DATA_BITS+1.5) + 4 clocks of the rx_i falling edge that starts the frame.
REQ-022 div_i SHALL be held stable while busy_o = 1; a change takes effect at the next counter compare, and the frame in progress is not guaranteed.
REQ-023 rx_i held low continuously (break) SHALL produce a frame with data 0 and frame_err_o = 1. The FSM then waits in IDLE; because rx_s is still low, it immediately re-enters START.

Reset
REQ-024 While rst_ni = 0, the following SHALL hold:
- synchronizer flops = 1;
- tick counter, s_cnt, n, shift register = 0;
- FSM = IDLE;
- data_o = 0, rx_done_o = 0, frame_err_o = 0, busy_o = 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame without an rx_done_o pulse; after release, the next complete frame SHALL be received correctly.

Verification (div_i = 16, bit period 272 clocks)
REQ-026 Reset check: release reset, idle line -> data_o = 0, rx_done_o = 0, frame_err_o = 0, busy_o = 0.
REQ-027 Single frame: drive 0xA5 (start 0, LSB first, stop 1) -> exactly one rx_done_o pulse; data_o = 0xA5, frame_err_o = 0; busy_o low afterwards.
REQ-028 Glitch: drive rx_i low for 100 clocks, then high -> no rx_done_o pulse; busy_o returns low within 140 clocks.
REQ-029 Framing error: drive 0x3C with the stop bit = 0 -> rx_done_o pulse, data_o = 0x3C, frame_err_o = 1. A following good 0x5A -> frame_err_o = 0.
REQ-030 Back-to-back loopback: 32 random bytes from uart_tx (same div_i) fed to rx_i with no idle gap -> 32 pulses, every data_o matches, frame_err_o = 0 throughout; repeat with div_i = 0.
REQ-031 Reset mid-frame: assert rst_ni during data bit 3 of 0xFF -> outputs reset, no pulse; after release, 0x81 is received correctly.
